// File: rtl/commit_trace_fifo.sv
// commit_trace_fifo: captures qualifying CPU writeback events as
// {register index, data, capture cycle} records and presents them in strict
// FIFO order on a valid/ready trace port. The oldest entry is held in a
// dedicated head register, so the trace outputs come from flops and an entry
// becomes visible one cycle after it is pushed. The port named rst is an
// asynchronous, active-low reset.
module commit_trace_fifo #(
    parameter int DEPTH = 8  // entry count; power of two, >= 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wb_wreg,
    input  logic [4:0]                 wb_wd,
    input  logic [31:0]                wb_wdata,
    input  logic                       clear,
    output logic                       trace_valid,
    input  logic                       trace_ready,
    output logic [4:0]                 trace_wd,
    output logic [31:0]                trace_wdata,
    output logic [31:0]                trace_cycle,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow,
    output logic [31:0]                commit_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    typedef struct packed {
        logic [4:0]  wd;
        logic [31:0] wdata;
        logic [31:0] cycle;
    } entry_t;

    entry_t          mem [DEPTH];
    entry_t          head;
    entry_t          push_entry;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   rd_ptr_nxt;
    logic [31:0]     cyc;
    logic            qualify;
    logic            full;
    logic            pop;
    logic            push_ok;

    // Decode this cycle's push/pop decisions and the record to be captured.
    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        qualify    = 1'b0;
        full       = 1'b0;
        pop        = 1'b0;
        push_ok    = 1'b0;
        rd_ptr_nxt = rd_ptr + PW'(1);
        push_entry = '{wd: wb_wd, wdata: wb_wdata, cycle: cyc + 32'd1};

        qualify = wb_wreg && (wb_wd != 5'd0);
        full    = (level == FULL_LEVEL);
        // An empty FIFO has nothing to pop, so trace_ready is ignored then.
        pop     = (level != '0) && trace_ready;
        // A full FIFO still accepts a push when the head leaves at the same edge.
        push_ok = qualify && (!full || pop);
    end

    // Free-running cycle counter; only reset affects it, never clear.
    // NOTE: sequential state always uses non-blocking assignments so every flop
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cyc <= 32'd0;
        end else begin
            cyc <= cyc + 32'd1;
        end
    end

    // Entry storage write port; a dropped or flushed push leaves storage untouched.
    // NOTE: the storage array is deliberately not reset -- validity is tracked by
    // level and the pointers, and the visible head lives in a separately reset register.
    always_ff @(posedge clk) begin
        if (!clear && push_ok) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    // Pointer, occupancy, status and head-register update.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            overflow     <= 1'b0;
            commit_count <= 32'd0;
            head         <= '0;
        end else if (clear) begin
            // Flush: drop queued entries and this cycle's push/pop; head
            // contents are stale but harmless because trace_valid falls.
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            overflow     <= 1'b0;
            commit_count <= 32'd0;
        end else begin
            if (qualify) begin
                commit_count <= commit_count + 32'd1;
            end
            if (qualify && !push_ok) begin
                overflow <= 1'b1;
            end
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr_nxt;
            end

            case ({push_ok, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase

            // The head register always mirrors the oldest valid entry.
            if (pop) begin
                if (level > LW'(1)) begin
                    head <= mem[rd_ptr_nxt];
                end else if (push_ok) begin
                    head <= push_entry;
                end
            end else if ((level == '0) && push_ok) begin
                head <= push_entry;
            end
        end
    end

    // Trace port driven straight from the head register and occupancy.
    always_comb begin
        trace_valid = (level != '0);
        trace_wd    = head.wd;
        trace_wdata = head.wdata;
        trace_cycle = head.cycle;
    end

endmodule

// File: tb/tb_commit_trace_fifo.sv
// Directed self-checking bench for commit_trace_fifo (DEPTH = 8).
// Inputs change 1 time unit after each rising edge; outputs are sampled there.
module tb_commit_trace_fifo;

    logic        clk;
    logic        rst;
    logic        wb_wreg;
    logic [4:0]  wb_wd;
    logic [31:0] wb_wdata;
    logic        clear;
    logic        trace_valid;
    logic        trace_ready;
    logic [4:0]  trace_wd;
    logic [31:0] trace_wdata;
    logic [31:0] trace_cycle;
    logic [3:0]  level;
    logic        overflow;
    logic [31:0] commit_count;

    int errors = 0;
    int checks = 0;
    int edge_no = 0;     // edges since the last reset release
    int push_edge = 0;

    commit_trace_fifo #(.DEPTH(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .wb_wreg      (wb_wreg),
        .wb_wd        (wb_wd),
        .wb_wdata     (wb_wdata),
        .clear        (clear),
        .trace_valid  (trace_valid),
        .trace_ready  (trace_ready),
        .trace_wd     (trace_wd),
        .trace_wdata  (trace_wdata),
        .trace_cycle  (trace_cycle),
        .level        (level),
        .overflow     (overflow),
        .commit_count (commit_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        edge_no++;
        #1;
    endtask

    task automatic idle_inputs();
        wb_wreg     = 1'b0;
        wb_wd       = 5'd0;
        wb_wdata    = 32'd0;
        clear       = 1'b0;
        trace_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();

        // Reset state (an edge passes while reset is held)
        #12;
        chk("rst_valid", 32'(trace_valid), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_count", commit_count, 32'd0);
        chk("rst_wd", 32'(trace_wd), 32'd0);
        chk("rst_wdata", trace_wdata, 32'd0);
        chk("rst_cycle", trace_cycle, 32'd0);
        rst = 1'b1;
        edge_no = 0;

        // First write after release: visible after edge 1 with cycle 1
        wb_wreg = 1'b1; wb_wd = 5'd1; wb_wdata = 32'h0000_1234; trace_ready = 1'b1;
        step();
        chk("e1_valid", 32'(trace_valid), 32'd1);
        chk("e1_wd", 32'(trace_wd), 32'd1);
        chk("e1_wdata", trace_wdata, 32'h0000_1234);
        chk("e1_cycle", trace_cycle, 32'd1);
        chk("e1_level", 32'(level), 32'd1);
        wb_wreg = 1'b0;
        step();
        chk("e2_level", 32'(level), 32'd0);
        chk("e2_valid", 32'(trace_valid), 32'd0);
        chk("e2_count", commit_count, 32'd1);

        // Writes to register 0 are ignored entirely
        clear = 1'b1;
        step();
        clear = 1'b0;
        wb_wreg = 1'b1; wb_wd = 5'd0; wb_wdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 5; i++) step();
        chk("r0_valid", 32'(trace_valid), 32'd0);
        chk("r0_count", commit_count, 32'd0);
        chk("r0_level", 32'(level), 32'd0);

        // Overfill with ready low: 9 writes, entry 9 dropped
        trace_ready = 1'b0;
        push_edge = edge_no + 1;
        for (int i = 1; i <= 9; i++) begin
            wb_wreg = 1'b1; wb_wd = 5'(i); wb_wdata = 32'hA0 + 32'(i);
            step();
        end
        wb_wreg = 1'b0;
        chk("ovf_level", 32'(level), 32'd8);
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_count", commit_count, 32'd9);
        chk("ovf_head_cycle", trace_cycle, 32'(push_edge));
        step();
        chk("hold_wd", 32'(trace_wd), 32'd1);
        chk("hold_wdata", trace_wdata, 32'hA1);
        trace_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            chk("drain_wd", 32'(trace_wd), 32'(i));
            chk("drain_wdata", trace_wdata, 32'hA0 + 32'(i));
            step();
        end
        chk("drain_level", 32'(level), 32'd0);
        chk("drain_valid", 32'(trace_valid), 32'd0);

        // Full FIFO with simultaneous push and pop
        trace_ready = 1'b0;
        clear = 1'b1;
        step();
        clear = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            wb_wreg = 1'b1; wb_wd = 5'(i); wb_wdata = 32'hB0 + 32'(i);
            step();
        end
        chk("full_level", 32'(level), 32'd8);
        wb_wd = 5'd9; wb_wdata = 32'hB9; trace_ready = 1'b1;
        step();
        wb_wreg = 1'b0;
        chk("pp_level", 32'(level), 32'd8);
        chk("pp_overflow", 32'(overflow), 32'd0);
        chk("pp_count", commit_count, 32'd9);
        for (int i = 2; i <= 9; i++) begin
            chk("pp_wd", 32'(trace_wd), 32'(i));
            chk("pp_wdata", trace_wdata, 32'hB0 + 32'(i));
            step();
        end
        chk("pp_empty", 32'(trace_valid), 32'd0);

        // Clear with 3 entries queued and overflow set
        trace_ready = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            wb_wreg = 1'b1; wb_wd = 5'(i); wb_wdata = 32'(i);
            step();
        end
        wb_wreg = 1'b0; trace_ready = 1'b1;
        for (int i = 0; i < 5; i++) step();
        trace_ready = 1'b0;
        chk("pre_clr_level", 32'(level), 32'd3);
        chk("pre_clr_ovf", 32'(overflow), 32'd1);
        chk("pre_clr_wd", 32'(trace_wd), 32'd6);
        clear = 1'b1; wb_wreg = 1'b1; wb_wd = 5'd7; wb_wdata = 32'h77;
        step();
        clear = 1'b0; wb_wreg = 1'b0;
        chk("clr_level", 32'(level), 32'd0);
        chk("clr_ovf", 32'(overflow), 32'd0);
        chk("clr_count", commit_count, 32'd0);
        chk("clr_valid", 32'(trace_valid), 32'd0);
        wb_wreg = 1'b1; wb_wd = 5'd12; wb_wdata = 32'hC0DE;
        step();
        wb_wreg = 1'b0;
        chk("post_clr_cycle", trace_cycle, 32'(edge_no));
        chk("post_clr_wd", 32'(trace_wd), 32'd12);

        // Asynchronous reset with 4 entries queued
        clear = 1'b1;
        step();
        clear = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            wb_wreg = 1'b1; wb_wd = 5'(i + 16); wb_wdata = 32'(i);
            step();
        end
        wb_wreg = 1'b0;
        chk("pre_rst_level", 32'(level), 32'd4);
        rst = 1'b0;
        #1;
        chk("arst_valid", 32'(trace_valid), 32'd0);
        chk("arst_level", 32'(level), 32'd0);
        chk("arst_count", commit_count, 32'd0);
        chk("arst_wd", 32'(trace_wd), 32'd0);
        #2;
        rst = 1'b1;
        edge_no = 0;
        wb_wreg = 1'b1; wb_wd = 5'd26; wb_wdata = 32'hDEAD_BEEF;
        step();
        wb_wreg = 1'b0;
        chk("rel_cycle", trace_cycle, 32'd1);
        chk("rel_wd", 32'(trace_wd), 32'd26);
        chk("rel_level", 32'(level), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
